// File: rtl/qpu_exu_disp_sb.sv
// QPU execution-unit dispatch stage with internal register/qubit scoreboard and registered
// valid/ready output toward the ALU. Define QPU_DISP_WB_BYPASS_EN for same-cycle retire bypass.
module qpu_exu_disp_sb #(
  parameter int unsigned RFIDX_W   = 5,
  parameter int unsigned QUBIT_NUM = 8,
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned LP_DEPTH  = 4,
  localparam int unsigned NREG     = 2 ** RFIDX_W,
  localparam int unsigned CNT_W    = $clog2(LP_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 disp_i_valid,
  output logic                 disp_i_ready,
  input  logic                 disp_i_rs1en,
  input  logic                 disp_i_rs2en,
  input  logic [RFIDX_W-1:0]   disp_i_rs1idx,
  input  logic [RFIDX_W-1:0]   disp_i_rs2idx,
  input  logic                 disp_i_rdwen,
  input  logic [RFIDX_W-1:0]   disp_i_rdidx,
  input  logic                 disp_i_longp,
  input  logic                 disp_i_measure,
  input  logic [QUBIT_NUM-1:0] disp_i_qlist,
  input  logic [PAYLOAD_W-1:0] disp_i_payload,
  output logic                 disp_o_valid,
  input  logic                 disp_o_ready,
  output logic [PAYLOAD_W-1:0] disp_o_payload,
  output logic                 disp_o_longp,
  output logic [RFIDX_W-1:0]   disp_o_rdidx,
  input  logic                 wb_i_valid,
  input  logic                 wb_i_rdwen,
  input  logic [RFIDX_W-1:0]   wb_i_rdidx,
  input  logic                 meas_i_valid,
  input  logic [QUBIT_NUM-1:0] meas_i_qlist,
  output logic [CNT_W-1:0]     disp_o_lp_cnt,
  output logic                 disp_o_err
);

  logic [NREG-1:0]      pend_rd_q, pend_rd_d;
  logic [QUBIT_NUM-1:0] pend_q_q, pend_q_d;
  logic [CNT_W-1:0]     lp_cnt_q, lp_cnt_d;
  logic                 err_q, err_d;

  logic [NREG-1:0]      wb_clear_mask;
  logic [NREG-1:0]      rd_set_mask;
  logic [QUBIT_NUM-1:0] meas_clear_mask;
  logic [NREG-1:0]      pend_rd_chk;
  logic [QUBIT_NUM-1:0] pend_q_chk;
  logic                 raw, waw, qdep, full, can_load, accept;
  logic                 lp_inc, lp_dec;

  always_comb begin
    wb_clear_mask = '0;
    rd_set_mask   = '0;
    if (wb_i_valid && wb_i_rdwen) wb_clear_mask[wb_i_rdidx] = 1'b1;
    // x0 is never tracked, so a write to it never blocks anything.
    if (accept && disp_i_longp && disp_i_rdwen && (disp_i_rdidx != '0)) begin
      rd_set_mask[disp_i_rdidx] = 1'b1;
    end
  end

  assign meas_clear_mask = meas_i_valid ? meas_i_qlist : '0;

`ifdef QPU_DISP_WB_BYPASS_EN
  assign pend_rd_chk = pend_rd_q & ~wb_clear_mask;
  assign pend_q_chk  = pend_q_q & ~meas_clear_mask;
  // A same-cycle retire frees a slot, so the counter nets out unchanged.
  assign full = disp_i_longp & (lp_cnt_q == CNT_W'(LP_DEPTH)) & ~wb_i_valid;
`else
  assign pend_rd_chk = pend_rd_q;
  assign pend_q_chk  = pend_q_q;
  assign full = disp_i_longp & (lp_cnt_q == CNT_W'(LP_DEPTH));
`endif

  assign raw  = (disp_i_rs1en & pend_rd_chk[disp_i_rs1idx])
              | (disp_i_rs2en & pend_rd_chk[disp_i_rs2idx]);
  assign waw  = disp_i_rdwen & pend_rd_chk[disp_i_rdidx];
  assign qdep = |(disp_i_qlist & pend_q_chk);

  assign can_load     = ~disp_o_valid | disp_o_ready;
  assign disp_i_ready = ~raw & ~waw & ~qdep & ~full & can_load;
  assign accept       = disp_i_valid & disp_i_ready;

  assign lp_inc = accept & disp_i_longp;
  assign lp_dec = wb_i_valid;

  always_comb begin
    pend_rd_d = (pend_rd_q & ~wb_clear_mask) | rd_set_mask;
    pend_q_d  = pend_q_q & ~meas_clear_mask;
    if (accept && disp_i_measure) pend_q_d = pend_q_d | disp_i_qlist;
    pend_rd_d[0] = 1'b0;

    lp_cnt_d = lp_cnt_q;
    err_d    = err_q;
    if (lp_inc && !lp_dec) begin
      lp_cnt_d = lp_cnt_q + CNT_W'(1);
    end else if (!lp_inc && lp_dec) begin
      if (lp_cnt_q == '0) err_d = 1'b1;
      else                lp_cnt_d = lp_cnt_q - CNT_W'(1);
    end

    if (wb_i_valid && wb_i_rdwen && (wb_i_rdidx != '0) && !pend_rd_q[wb_i_rdidx]) begin
      err_d = 1'b1;
    end
    if (meas_i_valid && |(meas_i_qlist & ~pend_q_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_rd_q <= '0;
      pend_q_q  <= '0;
      lp_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      pend_rd_q <= pend_rd_d;
      pend_q_q  <= pend_q_d;
      lp_cnt_q  <= lp_cnt_d;
      err_q     <= err_d;
    end
  end

  // Output register: loads only when empty or draining, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_o_valid   <= 1'b0;
      disp_o_payload <= '0;
      disp_o_longp   <= 1'b0;
      disp_o_rdidx   <= '0;
    end else if (can_load) begin
      disp_o_valid <= accept;
      if (accept) begin
        disp_o_payload <= disp_i_payload;
        disp_o_longp   <= disp_i_longp;
        disp_o_rdidx   <= disp_i_rdidx;
      end
    end
  end

  assign disp_o_lp_cnt = lp_cnt_q;
  assign disp_o_err    = err_q;

endmodule

// File: tb/tb_qpu_exu_disp_sb.sv
// Directed self-checking bench for qpu_exu_disp_sb (default build, LP_DEPTH=4).
module tb_qpu_exu_disp_sb;

  logic         clk = 1'b0;
  logic         rst;
  logic         disp_i_valid, disp_i_ready, disp_i_rs1en, disp_i_rs2en;
  logic [4:0]   disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx;
  logic         disp_i_rdwen, disp_i_longp, disp_i_measure;
  logic [7:0]   disp_i_qlist;
  logic [127:0] disp_i_payload;
  logic         disp_o_valid, disp_o_ready, disp_o_longp;
  logic [127:0] disp_o_payload;
  logic [4:0]   disp_o_rdidx;
  logic         wb_i_valid, wb_i_rdwen;
  logic [4:0]   wb_i_rdidx;
  logic         meas_i_valid;
  logic [7:0]   meas_i_qlist;
  logic [2:0]   disp_o_lp_cnt;
  logic         disp_o_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  qpu_exu_disp_sb #(
    .RFIDX_W(5), .QUBIT_NUM(8), .PAYLOAD_W(128), .LP_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_i_valid(disp_i_valid), .disp_i_ready(disp_i_ready),
    .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en),
    .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx),
    .disp_i_rdwen(disp_i_rdwen), .disp_i_rdidx(disp_i_rdidx),
    .disp_i_longp(disp_i_longp), .disp_i_measure(disp_i_measure),
    .disp_i_qlist(disp_i_qlist), .disp_i_payload(disp_i_payload),
    .disp_o_valid(disp_o_valid), .disp_o_ready(disp_o_ready),
    .disp_o_payload(disp_o_payload), .disp_o_longp(disp_o_longp),
    .disp_o_rdidx(disp_o_rdidx),
    .wb_i_valid(wb_i_valid), .wb_i_rdwen(wb_i_rdwen), .wb_i_rdidx(wb_i_rdidx),
    .meas_i_valid(meas_i_valid), .meas_i_qlist(meas_i_qlist),
    .disp_o_lp_cnt(disp_o_lp_cnt), .disp_o_err(disp_o_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    disp_i_valid = 0; disp_i_rs1en = 0; disp_i_rs2en = 0;
    disp_i_rs1idx = 0; disp_i_rs2idx = 0; disp_i_rdwen = 0; disp_i_rdidx = 0;
    disp_i_longp = 0; disp_i_measure = 0; disp_i_qlist = 0; disp_i_payload = 0;
    disp_o_ready = 1; wb_i_valid = 0; wb_i_rdwen = 0; wb_i_rdidx = 0;
    meas_i_valid = 0; meas_i_qlist = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic lp_instr(input logic [4:0] rd, input logic [127:0] pl);
    idle();
    disp_i_valid = 1; disp_i_longp = 1; disp_i_rdwen = 1; disp_i_rdidx = rd;
    disp_i_payload = pl;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_i_valid = 1; wb_i_rdwen = 1; wb_i_rdidx = rd;
  endtask

  initial begin
    rst = 1;
    idle();
    #12;
    chk("rst_o_valid", disp_o_valid, 0);
    chk("rst_o_payload", disp_o_payload, 0);
    chk("rst_lp_cnt", disp_o_lp_cnt, 0);
    chk("rst_err", disp_o_err, 0);
    chk("rst_ready", disp_i_ready, 1);
    rst = 0;
    tick();

    // Long-pipe write to r5, then a RAW consumer of r5.
    lp_instr(5, 128'hA5A5);
    settle(); chk("lp5_ready", disp_i_ready, 1);
    tick();
    chk("lp5_o_valid", disp_o_valid, 1);
    chk("lp5_o_rdidx", disp_o_rdidx, 5);
    chk("lp5_o_longp", disp_o_longp, 1);
    chk("lp5_o_payload", disp_o_payload, 128'hA5A5);
    chk("lp5_cnt", disp_o_lp_cnt, 1);
    idle();
    disp_i_valid = 1; disp_i_rs1en = 1; disp_i_rs1idx = 5; disp_i_payload = 128'hB0B;
    settle(); chk("raw_stall", disp_i_ready, 0);
    tick();
    chk("drain_o_valid", disp_o_valid, 0);
    wb(5);
    settle(); chk("raw_wb_same_cycle", disp_i_ready, 0);
    tick();
    wb_i_valid = 0; wb_i_rdwen = 0;
    settle();
    chk("raw_after_wb", disp_i_ready, 1);
    chk("wb5_cnt", disp_o_lp_cnt, 0);
    tick();
    chk("raw_issue_valid", disp_o_valid, 1);
    chk("raw_issue_payload", disp_o_payload, 128'hB0B);
    chk("raw_issue_longp", disp_o_longp, 0);

    // Fill the long pipe with rd 1..4.
    for (int i = 1; i <= 4; i++) begin
      lp_instr(5'(i), 128'(i));
      settle(); chk("fill_ready", disp_i_ready, 1);
      tick();
    end
    chk("fill_cnt", disp_o_lp_cnt, 4);
    chk("fill_o_rdidx", disp_o_rdidx, 4);
    lp_instr(6, 128'h66);
    settle(); chk("full_stall", disp_i_ready, 0);
    disp_i_longp = 0; disp_i_rdidx = 7; disp_i_payload = 128'h77;
    settle(); chk("full_short_ready", disp_i_ready, 1);
    tick();
    chk("short_cnt", disp_o_lp_cnt, 4);
    chk("short_o_longp", disp_o_longp, 0);
    chk("short_o_rdidx", disp_o_rdidx, 7);
    idle();
    disp_i_valid = 1; disp_i_rdwen = 1; disp_i_rdidx = 3;
    settle(); chk("waw_stall", disp_i_ready, 0);
    lp_instr(6, 128'h66);
    wb(1);
    settle(); chk("full_wb_no_bypass", disp_i_ready, 0);
    tick();
    chk("wb1_cnt", disp_o_lp_cnt, 3);
    wb(2);
    settle(); chk("acc_wb_ready", disp_i_ready, 1);
    tick();
    chk("acc_wb_cnt", disp_o_lp_cnt, 3);
    chk("acc_wb_o_rdidx", disp_o_rdidx, 6);
    idle(); wb(3); tick();
    idle(); wb(4); tick();
    idle(); wb(6); tick();
    idle(); settle();
    chk("drain_cnt", disp_o_lp_cnt, 0);
    chk("drain_err", disp_o_err, 0);

    // Qubit dependencies through measures.
    idle();
    disp_i_valid = 1; disp_i_measure = 1; disp_i_qlist = 8'h03; disp_i_payload = 128'hC1;
    settle(); chk("meas1_ready", disp_i_ready, 1);
    tick();
    idle();
    disp_i_valid = 1; disp_i_measure = 1; disp_i_qlist = 8'h02; disp_i_payload = 128'hC2;
    settle(); chk("qdep_stall", disp_i_ready, 0);
    meas_i_valid = 1; meas_i_qlist = 8'h01;
    tick();
    meas_i_valid = 0;
    settle(); chk("qdep_partial", disp_i_ready, 0);
    meas_i_valid = 1; meas_i_qlist = 8'h02;
    settle(); chk("qdep_same_cycle", disp_i_ready, 0);
    tick();
    meas_i_valid = 0;
    settle(); chk("qdep_cleared", disp_i_ready, 1);
    tick();
    chk("meas2_payload", disp_o_payload, 128'hC2);
    idle(); meas_i_valid = 1; meas_i_qlist = 8'h02; tick();
    idle(); settle();
    chk("meas_err", disp_o_err, 0);

    // Output backpressure then back-to-back loads.
    idle();
    disp_o_ready = 0; disp_i_valid = 1; disp_i_payload = 128'hC;
    settle(); chk("bp_load_ready", disp_i_ready, 1);
    tick();
    chk("bp_o_valid", disp_o_valid, 1);
    chk("bp_o_payload", disp_o_payload, 128'hC);
    disp_i_payload = 128'hD;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("bp_ready_low", disp_i_ready, 0);
      tick();
      chk("bp_hold_payload", disp_o_payload, 128'hC);
      chk("bp_hold_valid", disp_o_valid, 1);
    end
    disp_o_ready = 1;
    settle(); chk("bp_release_ready", disp_i_ready, 1);
    tick();
    chk("b2b_d", disp_o_payload, 128'hD);
    disp_i_payload = 128'hE;
    tick();
    chk("b2b_e", disp_o_payload, 128'hE);
    chk("b2b_e_valid", disp_o_valid, 1);
    idle(); tick();
    chk("b2b_drain", disp_o_valid, 0);

    // Underflowing retire raises the sticky error.
    idle(); wb_i_valid = 1; tick();
    idle(); settle();
    chk("uflow_err", disp_o_err, 1);
    chk("uflow_cnt", disp_o_lp_cnt, 0);
    tick();
    chk("err_sticky", disp_o_err, 1);

    // Asynchronous reset mid-stream.
    lp_instr(9, 128'hF00D);
    tick();
    idle();
    chk("pre_rst_valid", disp_o_valid, 1);
    chk("pre_rst_cnt", disp_o_lp_cnt, 1);
    rst = 1;
    #1;
    chk("mid_rst_valid", disp_o_valid, 0);
    chk("mid_rst_payload", disp_o_payload, 0);
    chk("mid_rst_longp", disp_o_longp, 0);
    chk("mid_rst_rdidx", disp_o_rdidx, 0);
    chk("mid_rst_cnt", disp_o_lp_cnt, 0);
    chk("mid_rst_err", disp_o_err, 0);
    rst = 0;
    disp_i_valid = 1; disp_i_rs1en = 1; disp_i_rs1idx = 9; disp_i_payload = 128'h99;
    settle(); chk("post_rst_ready", disp_i_ready, 1);
    tick();
    chk("post_rst_payload", disp_o_payload, 128'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
